// File: rtl/uart_word_assembler_if.sv
// rtl/uart_word_assembler_if.sv - UART byte/boot/runtime signal bundle for the word assembler
interface uart_word_assembler_if;
  logic        rx_ready;
  logic [7:0]  rdata;
  logic        tx_busy;
  logic        boot_we;
  logic [31:0] boot_addr;
  logic [31:0] boot_wd;
  logic        boot_done;
  logic        data_ready;
  logic [31:0] data;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        length_error;

  // Driver side: UART receiver/transmitter environment.
  modport master (
    output rx_ready, rdata, tx_busy,
    input  boot_we, boot_addr, boot_wd, boot_done,
    input  data_ready, data, tx_start, sdata, length_error
  );

  // Assembler side.
  modport slave (
    input  rx_ready, rdata, tx_busy,
    output boot_we, boot_addr, boot_wd, boot_done,
    output data_ready, data, tx_start, sdata, length_error
  );
endinterface

// File: rtl/uart_word_assembler.sv
// rtl/uart_word_assembler.sv - assembles UART bytes into words for boot loading and runtime data
module uart_word_assembler #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000,
  parameter logic [31:0] BOOT_MAX_WORDS = 32'h5000
) (
  input logic                  clock,
  input logic                  reset,
  uart_word_assembler_if.slave bus
);

  typedef enum logic [1:0] {HEADER, LOAD, ACK, RUN} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  logic [31:0] idle_cnt;
  logic [31:0] word_cnt;
  logic [31:0] length;
  logic        word_done;
  logic [31:0] word;

  // The 4th byte completes the word combinationally so the FSM can register it on the same edge.
  always_comb begin
    word_done = bus.rx_ready && (byte_cnt == 2'd3);
    word      = {bus.rdata, partial};
  end

  // Little-endian byte packing with an idle timeout that drops a stalled partial word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      byte_cnt <= 2'd0;
      partial  <= 24'd0;
      idle_cnt <= 32'd0;
    end else if (bus.rx_ready) begin
      if (byte_cnt != 2'd3) begin
        partial[{byte_cnt, 3'b000} +: 8] <= bus.rdata;
      end
      byte_cnt <= byte_cnt + 2'd1;
      idle_cnt <= 32'd0;
    end else if (byte_cnt == 2'd0) begin
      idle_cnt <= 32'd0;
    end else if (idle_cnt + 32'd1 >= TIMEOUT_CYCLES) begin
      // Stale lanes need no clearing: each later byte overwrites its own lane.
      byte_cnt <= 2'd0;
      idle_cnt <= 32'd0;
    end else begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  // Boot protocol FSM: header length, program load, one-shot acknowledge, then runtime words.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= HEADER;
      word_cnt         <= 32'd0;
      length           <= 32'd0;
      bus.boot_we      <= 1'b0;
      bus.boot_addr    <= 32'd0;
      bus.boot_wd      <= 32'd0;
      bus.boot_done    <= 1'b0;
      bus.data_ready   <= 1'b0;
      bus.data         <= 32'd0;
      bus.tx_start     <= 1'b0;
      bus.sdata        <= 8'd0;
      bus.length_error <= 1'b0;
    end else begin
      bus.boot_we    <= 1'b0;
      bus.data_ready <= 1'b0;
      bus.tx_start   <= 1'b0;
      case (state)
        HEADER: begin
          if (word_done) begin
            word_cnt <= 32'd0;
            if (word == 32'd0) begin
              state <= ACK;
            end else if (word > BOOT_MAX_WORDS) begin
              bus.length_error <= 1'b1;
              length           <= BOOT_MAX_WORDS;
              state            <= (BOOT_MAX_WORDS == 32'd0) ? ACK : LOAD;
            end else begin
              length <= word;
              state  <= LOAD;
            end
          end
        end
        LOAD: begin
          if (word_done) begin
            bus.boot_we   <= 1'b1;
            bus.boot_addr <= word_cnt;
            bus.boot_wd   <= word;
            word_cnt      <= word_cnt + 32'd1;
            if (word_cnt == length - 32'd1) begin
              state <= ACK;
            end
          end
        end
        ACK: begin
          // Bytes keep flowing while the acknowledge waits; finished words are already runtime data.
          if (word_done) begin
            bus.data_ready <= 1'b1;
            bus.data       <= word;
          end
          if (!bus.tx_busy) begin
            bus.tx_start  <= 1'b1;
            bus.sdata     <= 8'hAA;
            bus.boot_done <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          if (word_done) begin
            bus.data_ready <= 1'b1;
            bus.data       <= word;
          end
        end
        default: state <= HEADER;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_assembler.sv
// tb/tb_uart_word_assembler.sv - self-checking bench for uart_word_assembler
module tb_uart_word_assembler;

  localparam logic [31:0] TO   = 32'd20;
  localparam logic [31:0] MAXW = 32'd4;

  logic clk;
  logic rstn;

  uart_word_assembler_if bus ();

  uart_word_assembler #(
    .TIMEOUT_CYCLES(TO),
    .BOOT_MAX_WORDS(MAXW)
  ) dut (
    .clock(clk),
    .reset(rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];

  int n_total = 0;
  int n_pass  = 0;
  int n_bwe   = 0;
  int n_dr    = 0;
  int n_tx    = 0;
  int n_viol  = 0;
  logic [31:0] q_baddr [$];
  logic [31:0] q_bwd   [$];
  logic [31:0] q_data  [$];

  // Event monitor: records every strobe and flags forbidden strobe combinations.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.boot_we) begin
        n_bwe = n_bwe + 1;
        q_baddr.push_back(bus.boot_addr);
        q_bwd.push_back(bus.boot_wd);
      end
      if (bus.data_ready) begin
        n_dr = n_dr + 1;
        q_data.push_back(bus.data);
      end
      if (bus.tx_start) n_tx = n_tx + 1;
      if (bus.boot_we && (bus.data_ready || bus.boot_done)) n_viol = n_viol + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_ready = 1'b1;
    bus.rdata    = b;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, 32'({bus.boot_we, bus.data_ready, bus.tx_start, bus.boot_done, bus.length_error}), 32'd0);
    check({tag, "_boot_addr"}, bus.boot_addr, 32'd0);
    check({tag, "_boot_wd"}, bus.boot_wd, 32'd0);
    check({tag, "_data"}, bus.data, 32'd0);
    check({tag, "_sdata"}, 32'(bus.sdata), 32'd0);
  endtask

  initial begin
    int dr0, bwe0, tx0, qb0;
    vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    vecs[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};

    rstn = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rdata = 8'd0;
    bus.tx_busy = 1'b0;
    @(negedge clk);
    do_reset();
    check_all_zero("reset");

    // Boot with two program words.
    send_word(32'd2);
    check("hdr_no_we", 32'(bus.boot_we), 32'd0);
    send_word(32'h12345678);
    check("boot0_we", 32'(bus.boot_we), 32'd1);
    check("boot0_addr", bus.boot_addr, 32'd0);
    check("boot0_wd", bus.boot_wd, 32'h12345678);
    send_word(32'hDEADBEEF);
    check("boot1_we", 32'(bus.boot_we), 32'd1);
    check("boot1_addr", bus.boot_addr, 32'd1);
    check("boot1_wd", bus.boot_wd, 32'hDEADBEEF);
    @(negedge clk);
    check("ack_tx_start", 32'(bus.tx_start), 32'd1);
    check("ack_sdata", 32'(bus.sdata), 32'h000000AA);
    check("ack_boot_done", 32'(bus.boot_done), 32'd1);
    @(negedge clk);
    check("ack_tx_pulse", 32'(bus.tx_start), 32'd0);
    check("boot_wd_hold", bus.boot_wd, 32'hDEADBEEF);

    // Runtime words from the vector table.
    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].b0);
      send_byte(vecs[i].b1);
      send_byte(vecs[i].b2);
      send_byte(vecs[i].b3);
      check($sformatf("rt%0d_ready", i), 32'(bus.data_ready), 32'd1);
      check($sformatf("rt%0d_data", i), bus.data, vecs[i].exp);
      check($sformatf("rt%0d_no_we", i), 32'(bus.boot_we), 32'd0);
      repeat (2) @(negedge clk);
      check($sformatf("rt%0d_pulse", i), 32'(bus.data_ready), 32'd0);
      check($sformatf("rt%0d_hold", i), bus.data, vecs[i].exp);
    end

    // Timeout: exactly TO idle cycles discards, TO-1 does not.
    dr0 = n_dr;
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (int'(TO)) @(negedge clk);
    send_word(32'h44332211);
    check("to_ready", 32'(bus.data_ready), 32'd1);
    check("to_data", bus.data, 32'h44332211);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (int'(TO) - 1) @(negedge clk);
    send_byte(8'h11);
    send_byte(8'h22);
    check("to_edge_ready", 32'(bus.data_ready), 32'd1);
    check("to_edge_data", bus.data, 32'h2211BBAA);
    repeat (2) @(negedge clk);
    check("to_count", 32'(n_dr - dr0), 32'd2);

    // Zero length goes straight to acknowledge.
    do_reset();
    bwe0 = n_bwe;
    send_word(32'd0);
    check("zero_no_we", 32'(bus.boot_we), 32'd0);
    @(negedge clk);
    check("zero_tx_start", 32'(bus.tx_start), 32'd1);
    check("zero_boot_done", 32'(bus.boot_done), 32'd1);
    repeat (2) @(negedge clk);
    check("zero_we_count", 32'(n_bwe - bwe0), 32'd0);

    // Oversize length is clamped; surplus words become runtime data.
    do_reset();
    bwe0 = n_bwe; dr0 = n_dr; tx0 = n_tx; qb0 = q_baddr.size();
    send_word(MAXW + 32'd5);
    check("over_len_err", 32'(bus.length_error), 32'd1);
    check("over_hdr_no_we", 32'(bus.boot_we), 32'd0);
    for (int i = 0; i < 9; i++) send_word(32'h100 + 32'(i));
    repeat (2) @(negedge clk);
    check("over_we_count", 32'(n_bwe - bwe0), 32'd4);
    check("over_last_addr", q_baddr[qb0 + 3], 32'd3);
    check("over_last_wd", q_bwd[qb0 + 3], 32'h103);
    check("over_dr_count", 32'(n_dr - dr0), 32'd5);
    check("over_last_data", q_data[q_data.size() - 1], 32'h108);
    check("over_tx_count", 32'(n_tx - tx0), 32'd1);
    check("over_err_sticky", 32'(bus.length_error), 32'd1);

    // Acknowledge stalled by tx_busy; a word completes during the stall.
    do_reset();
    tx0 = n_tx;
    bus.tx_busy = 1'b1;
    send_word(32'd1);
    send_word(32'h55AA55AA);
    send_word(32'hCAFEF00D);
    check("stall_ready", 32'(bus.data_ready), 32'd1);
    check("stall_data", bus.data, 32'hCAFEF00D);
    repeat (46) @(negedge clk);
    check("stall_no_tx", 32'(bus.tx_start), 32'd0);
    check("stall_not_done", 32'(bus.boot_done), 32'd0);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    check("stall_tx_start", 32'(bus.tx_start), 32'd1);
    check("stall_sdata", 32'(bus.sdata), 32'h000000AA);
    for (int i = 0; i < 10; i++) begin
      bus.tx_busy = i[0];
      @(negedge clk);
    end
    bus.tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("stall_tx_once", 32'(n_tx - tx0), 32'd1);

    // Reset mid-load, with a byte offered while reset is asserted.
    do_reset();
    send_word(32'd3);
    send_word(32'hA1A1A1A1);
    send_word(32'hB2B2B2B2);
    rstn = 1'b0;
    bus.rx_ready = 1'b1;
    bus.rdata = 8'h77;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("midrst");
    rstn = 1'b1;
    send_word(32'd2);
    check("reload_hdr_no_we", 32'(bus.boot_we), 32'd0);
    send_word(32'hC3C3C3C3);
    check("reload0_addr", bus.boot_addr, 32'd0);
    check("reload0_wd", bus.boot_wd, 32'hC3C3C3C3);
    send_word(32'hD4D4D4D4);
    check("reload1_addr", bus.boot_addr, 32'd1);
    check("reload1_wd", bus.boot_wd, 32'hD4D4D4D4);
    @(negedge clk);
    check("reload_tx_start", 32'(bus.tx_start), 32'd1);
    check("reload_boot_done", 32'(bus.boot_done), 32'd1);

    repeat (2) @(negedge clk);
    check("strobe_exclusion", 32'(n_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd100000, meaning the idle cycles after which a partial word is discarded.
REQ-002 SHALL have parameter BOOT_MAX_WORDS, default 32'h5000, meaning the maximum number of program words loaded into instruction BRAM.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port rx_ready, input, 1 bit: one-cycle pulse from UartRx, indicating rdata is valid.
REQ-006 SHALL have port rdata, input, 8 bits: received byte.
REQ-007 SHALL have port boot_we, output, 1 bit: one-cycle instruction-BRAM write strobe.
REQ-008 SHALL have port boot_addr, output, 32 bits: BRAM word index for boot_wd.
REQ-009 SHALL have port boot_wd, output, 32 bits: program word.
REQ-010 SHALL have port boot_done, output, 1 bit: level; high once the program is loaded and acknowledged.
REQ-011 SHALL have port data_ready, output, 1 bit: one-cycle pulse feeding MemoryControllerHub data_ready.
REQ-012 SHALL have port data, output, 32 bits: runtime word feeding MemoryControllerHub data.
REQ-013 SHALL have port tx_start, output, 1 bit: one-cycle UartTx start pulse.
REQ-014 SHALL have port sdata, output, 8 bits: UartTx byte.
REQ-015 SHALL have port tx_busy, input, 1 bit: UartTx busy.
REQ-016 SHALL have port length_error, output, 1 bit: sticky flag; the header length exceeded BOOT_MAX_WORDS.

Function
REQ-017 SHALL pack bytes little-endian: 1st byte to [7:0], 2nd to [15:8], 3rd to [23:16], 4th to [31:24].
REQ-018 SHALL keep a 2-bit byte counter that wraps 3->0 on the 4th byte; the word completes on that byte.
REQ-019 SHALL register a completed word and its strobe (boot_we or data_ready) exactly one cycle after the 4th rx_ready; latency is 1 cycle.
REQ-020 SHALL apply a timeout while the byte counter is 1-3: an idle counter counts cycles without rx_ready.
- On reaching TIMEOUT_CYCLES: byte counter to 0, partial word discarded, no strobe.
- The idle counter clears on every rx_ready and while the byte counter is 0.
REQ-021 SHALL implement FSM states HEADER, LOAD, ACK, RUN; reset state is HEADER.
REQ-022 SHALL, in HEADER, store the first completed word as length L and emit no strobe.
- If L == 0: go to ACK.
- If L > BOOT_MAX_WORDS: set length_error, use BOOT_MAX_WORDS as L, go to LOAD.
- Otherwise: go to LOAD.
REQ-023 SHALL, in LOAD, for each completed word pulse boot_we with boot_addr = k and boot_wd = word, for k = 0..L-1; after word k = L-1 go to ACK.
REQ-024 SHALL, in ACK, wait while tx_busy = 1. At the first cycle with tx_busy = 0, pulse tx_start for 1 cycle with sdata = 8'hAA, set boot_done, and go to RUN.
REQ-025 SHALL keep byte assembly running during ACK; a word completed in ACK is emitted on data/data_ready as a runtime word.
REQ-026 SHALL, in RUN, pulse data_ready for each completed word and remain in RUN until reset.
REQ-027 SHALL never assert boot_we and data_ready in the same cycle, and SHALL never assert boot_we once boot_done = 1.
REQ-028 SHALL hold data, boot_wd and boot_addr at their last values between strobes.
REQ-029 SHALL count words in LOAD with a 32-bit counter and compare using unsigned arithmetic.
REQ-030 SHALL ignore tx_busy outside ACK, and SHALL assert tx_start only once after each reset.

Reset
REQ-031 SHALL, while reset = 0 at a clock edge, set:
- state to HEADER;
- byte counter, idle counter and word counter to 0;
- boot_we, data_ready, tx_start, boot_done and length_error to 0;
- boot_addr, boot_wd, data and sdata to 0.
REQ-032 SHALL discard any partial word on a reset asserted mid-word or mid-load; the BRAM contents written so far are not retracted.
REQ-033 SHALL ignore rx_ready sampled in a cycle with reset = 0.

Verification
REQ-034 Boot: bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE -> boot_we at addr 0 with wd 32'h12345678, then addr 1 with 32'hDEADBEEF; then tx_start with sdata 8'hAA, boot_done = 1.
REQ-035 Runtime: after boot, bytes 01 02 03 04 -> data_ready one cycle after the 4th byte, data = 32'h04030201; boot_we stays 0.
REQ-036 Timeout: in RUN, bytes AA BB, then TIMEOUT_CYCLES idle, then 11 22 33 44 -> single data_ready with data = 32'h44332211.
REQ-037 Zero/oversize length: L = 0 -> immediate ACK, no boot_we. L = BOOT_MAX_WORDS+5 -> length_error = 1, exactly BOOT_MAX_WORDS boot_we, and the following words appear on data_ready.
REQ-038 ACK stall: tx_busy = 1 for 50 cycles at ACK entry -> tx_start is asserted on the first cycle tx_busy = 0, then never again; a word completed during the stall is emitted on data_ready.
REQ-039 Mid-load reset: reset = 0 after 2 of 3 boot words -> all outputs 0, state HEADER; a fresh header then reloads starting at addr 0.
